// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the 8-bit register file and the sequencer
// that drives it.
package reg_file_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 8;
  localparam int RF_OP_W   = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MOV  = 3'b101,
    OP_SLTU = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_file_alu.sv
// Combinational ALU: (op, a, b) -> (result, illegal).
// Opcode 111 (MUL) is legal only when REG_FILE_SEQUENCER_MUL_EN is defined.
module reg_file_alu
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int OP_W   = RF_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MUL: begin
`ifdef REG_FILE_SEQUENCER_MUL_EN
        result = a * b;
`else
        // Illegal op reports a zero result so done_result is deterministic.
        illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_file_sequencer.sv
// Four-state initiator for the two-read/one-write register file: accept, read,
// execute, write back. MUL support is selected by REG_FILE_SEQUENCER_MUL_EN.
module reg_file_sequencer
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int OP_W   = RF_OP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] rf_r1_addr,
  output logic [ADDR_W-1:0] rf_r2_addr,
  input  logic [DATA_W-1:0] rf_r1_data,
  input  logic [DATA_W-1:0] rf_r2_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_ctrl,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic              done_err
);

  state_e            state_reg;
  logic [OP_W-1:0]   op_reg;
  logic [ADDR_W-1:0] src1_reg;
  logic [ADDR_W-1:0] src2_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  // Read addresses come straight from the latch, so they hold between commands.
  assign rf_r1_addr = src1_reg;
  assign rf_r2_addr = src2_reg;

  reg_file_alu #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_alu (
    .op     (op_reg),
    .a      (rf_r1_data),
    .b      (rf_r2_data),
    .result (alu_result),
    .illegal(alu_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= '0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      dst_reg       <= '0;
      cmd_ready     <= 1'b1;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_write_ctrl <= 1'b0;
      done_valid    <= 1'b0;
      done_result   <= '0;
      done_err      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_op;
            src1_reg  <= cmd_src1;
            src2_reg  <= cmd_src2;
            dst_reg   <= cmd_dst;
            cmd_ready <= 1'b0;
            state_reg <= ST_READ;
          end
        end
        ST_READ: state_reg <= ST_EXEC;
        ST_EXEC: begin
          // Read data is valid now; everything the WRITE cycle shows is registered here.
          rf_write_addr <= dst_reg;
          rf_write_data <= alu_result;
          rf_write_ctrl <= ~alu_illegal;
          done_result   <= alu_result;
          done_err      <= alu_illegal;
          done_valid    <= 1'b1;
          state_reg     <= ST_WRITE;
        end
        ST_WRITE: begin
          rf_write_ctrl <= 1'b0;
          done_valid    <= 1'b0;
          cmd_ready     <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
